// File: rtl/memory_stage_if.sv
// Bus bundle between the execute side and the memory stage.
// master drives the operands and start; slave returns valM, done, busy and stat.
interface memory_stage_if;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] valM;
    logic        done;
    logic        busy;
    logic [2:0]  stat;

    modport master (
        output start, icode, valE, valA, valP,
        output instr_valid, imem_error,
        input  valM, done, busy, stat
    );

    modport slave (
        input  start, icode, valE, valA, valP,
        input  instr_valid, imem_error,
        output valM, done, busy, stat
    );
endinterface

// File: rtl/memory_stage.sv
// Y86-style memory stage: one 8-byte little-endian data access per start.
// Ports: clk, rst (sync, active-high), bus (memory_stage_if.slave).
module memory_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    memory_stage_if.slave bus
);
    localparam int          AW   = $clog2(MEM_BYTES);
    localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic        start_q;
    logic [3:0]  icode_q;
    logic [63:0] vale_q, vala_q, valp_q;
    logic        iv_q, ie_q;
    logic [63:0] valm_q;
    logic [2:0]  stat_q;
    logic        done_q;

    logic [7:0]  mem_q [MEM_BYTES];

    logic        accept;
    logic        is_wr, is_rd;
    logic        addr_ok, wr_en, busy;
    logic [63:0] addr, wdata, rdata, valm_d;
    logic [2:0]  stat_d;
    logic [AW-1:0] idx;

    // Rising-edge detect so a start held high launches only one access.
    assign accept = bus.start && !start_q && (state_q == S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_ACCESS;
            S_ACCESS: state_d = (stat_d == AOK) ? S_IDLE : S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        is_wr = 1'b0;
        is_rd = 1'b0;
        addr  = vale_q;
        wdata = vala_q;
        unique case (1'b1)
            icode_q == I_RMMOVQ,
            icode_q == I_PUSHQ: is_wr = 1'b1;
            icode_q == I_CALL: begin
                is_wr = 1'b1;
                wdata = valp_q;
            end
            icode_q == I_MRMOVQ: is_rd = 1'b1;
            icode_q == I_POPQ,
            icode_q == I_RET: begin
                is_rd = 1'b1;
                addr  = vala_q;
            end
            default: ;
        endcase

        // Unsigned compare against the last legal base also rejects
        // addresses whose +7 would wrap around 2^64.
        addr_ok = (addr <= LAST);
        idx     = addr[AW-1:0];

        rdata = '0;
        for (int i = 0; i < 8; i++)
            rdata[8*i +: 8] = mem_q[idx + AW'(i)];

        if (ie_q)                      stat_d = ADR;
        else if (!iv_q)                stat_d = INS;
        else if ((is_wr || is_rd) && !addr_ok) stat_d = ADR;
        else if (icode_q == I_HALT)    stat_d = HLT;
        else                           stat_d = AOK;

        if ((is_wr || is_rd) && !addr_ok) valm_d = '0;
        else if (is_rd)                   valm_d = rdata;
        else                              valm_d = valm_q;

        busy  = (state_q == S_ACCESS);
        wr_en = busy && is_wr && addr_ok && iv_q && !ie_q && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            icode_q <= '0;
            vale_q  <= '0;
            vala_q  <= '0;
            valp_q  <= '0;
            iv_q    <= 1'b1;
            ie_q    <= 1'b0;
            valm_q  <= '0;
            stat_q  <= AOK;
            done_q  <= 1'b0;
        end else begin
            start_q <= bus.start;
            done_q  <= (state_q == S_ACCESS);
            if (accept) begin
                icode_q <= bus.icode;
                vale_q  <= bus.valE;
                vala_q  <= bus.valA;
                valp_q  <= bus.valP;
                iv_q    <= bus.instr_valid;
                ie_q    <= bus.imem_error;
            end
            if (state_q == S_ACCESS) begin
                valm_q <= valm_d;
                stat_q <= stat_d;
            end
        end
    end

    // Data memory is never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++)
                mem_q[idx + AW'(i)] <= wdata[8*i +: 8];
        end
    end

    assign bus.valM = valm_q;
    assign bus.done = done_q;
    assign bus.busy = busy;
    assign bus.stat = stat_q;
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table plus corner sequences.
// Expected valM/stat are queued at drive time and popped on done.
module tb_memory_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    memory_stage_if bus ();

    memory_stage #(.MEM_BYTES(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [63:0] valP;
        logic [63:0] exp_valM;
        logic [2:0]  exp_stat;
    } vec_t;

    typedef struct {
        logic [63:0] valM;
        logic [2:0]  stat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(logic [3:0] ic, logic [63:0] e, logic [63:0] a,
                         logic [63:0] p, logic iv, logic ie);
        bus.icode       = ic;
        bus.valE        = e;
        bus.valA        = a;
        bus.valP        = p;
        bus.instr_valid = iv;
        bus.imem_error  = ie;
        bus.start       = 1'b1;
    endtask

    task automatic run_op(string name, logic [3:0] ic, logic [63:0] e,
                          logic [63:0] a, logic [63:0] p, logic iv,
                          logic ie, logic [63:0] ev, logic [2:0] es);
        exp_t x;
        int   cyc;
        bit   seen;
        logic busy1;
        sb.push_back('{ev, es});
        @(negedge clk);
        drive(ic, e, a, p, iv, ie);
        cyc   = 0;
        seen  = 0;
        busy1 = 1'b0;
        while (!seen && cyc < 6) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                busy1 = bus.busy;
                bus.start = 1'b0;
            end
            if (bus.done) seen = 1;
        end
        x = sb.pop_front();
        chk({name, " done_seen"}, 64'(seen), 64'd1);
        chk({name, " latency"}, 64'(cyc), 64'd2);
        chk({name, " busy"}, 64'(busy1), 64'd1);
        chk({name, " valM"}, bus.valM, x.valM);
        chk({name, " stat"}, 64'(bus.stat), 64'(x.stat));
    endtask

    // Pulse start while HALTED and confirm nothing responds.
    task automatic no_done(string name, logic [63:0] ev, logic [2:0] es);
        int dones;
        dones = 0;
        @(negedge clk);
        drive(4'd5, 64'h10, 64'h0, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) dones++;
        end
        chk({name, " dones"}, 64'(dones), 64'd0);
        chk({name, " valM"}, bus.valM, ev);
        chk({name, " stat"}, 64'(bus.stat), 64'(es));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   dones;
        logic busy1;

        vecs[0] = '{4'd4,  64'h10,  64'h1122334455667788, 64'h0,
                    64'h0, 3'd1};
        vecs[1] = '{4'd4,  64'h08,  64'h0, 64'h0, 64'h0, 3'd1};
        vecs[2] = '{4'd5,  64'h10,  64'h0, 64'h0,
                    64'h1122334455667788, 3'd1};
        vecs[3] = '{4'd5,  64'h0C,  64'h0, 64'h0,
                    64'h5566778800000000, 3'd1};
        vecs[4] = '{4'd10, 64'h3F8, 64'h5, 64'h0,
                    64'h5566778800000000, 3'd1};
        vecs[5] = '{4'd11, 64'h400, 64'h3F8, 64'h0, 64'h5, 3'd1};
        vecs[6] = '{4'd8,  64'h3F0, 64'h99, 64'h40, 64'h5, 3'd1};
        vecs[7] = '{4'd9,  64'h3F8, 64'h3F0, 64'h0, 64'h40, 3'd1};
        vecs[8] = '{4'd5,  64'h3F8, 64'h0, 64'h0, 64'h5, 3'd1};
        vecs[9] = '{4'd3,  64'h3F9, 64'h0, 64'h0, 64'h5, 3'd1};

        bus.start       = 1'b0;
        bus.icode       = '0;
        bus.valE        = '0;
        bus.valA        = '0;
        bus.valP        = '0;
        bus.instr_valid = 1'b1;
        bus.imem_error  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset valM", bus.valM, 64'h0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset stat", 64'(bus.stat), 64'd1);

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].icode, vecs[i].valE,
                   vecs[i].valA, vecs[i].valP, 1'b1, 1'b0,
                   vecs[i].exp_valM, vecs[i].exp_stat);

        // Just past the top of memory: ADR, no write, halted.
        run_op("st_3F9", 4'd4, 64'h3F9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
               1'b1, 1'b0, 64'h0, 3'd3);
        no_done("halt_adr", 64'h0, 3'd3);
        do_reset();
        run_op("ld_3F8_after", 4'd5, 64'h3F8, 64'h0, 64'h0,
               1'b1, 1'b0, 64'h5, 3'd1);

        // Wrapping address.
        run_op("ld_wrap", 4'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0,
               1'b1, 1'b0, 64'h0, 3'd3);
        do_reset();

        // Halt instruction keeps previous valM.
        run_op("ld_pre_halt", 4'd5, 64'h10, 64'h0, 64'h0,
               1'b1, 1'b0, 64'h1122334455667788, 3'd1);
        run_op("halt", 4'd0, 64'h0, 64'h0, 64'h0,
               1'b1, 1'b0, 64'h1122334455667788, 3'd2);
        no_done("halt_hlt", 64'h1122334455667788, 3'd2);
        do_reset();

        // Illegal instruction must not store.
        run_op("ins_st", 4'd4, 64'h10, 64'hDEAD, 64'h0,
               1'b0, 1'b0, 64'h0, 3'd4);
        do_reset();
        run_op("ld_after_ins", 4'd5, 64'h10, 64'h0, 64'h0,
               1'b1, 1'b0, 64'h1122334455667788, 3'd1);
        do_reset();

        // imem_error outranks instr_valid=0.
        run_op("imem_err", 4'd1, 64'h0, 64'h0, 64'h0,
               1'b0, 1'b1, 64'h0, 3'd3);
        do_reset();

        // Reset during ACCESS drops the pending store.
        run_op("st_20", 4'd4, 64'h20, 64'h0123456789ABCDEF, 64'h0,
               1'b1, 1'b0, 64'h0, 3'd1);
        @(negedge clk);
        drive(4'd4, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst done", 64'(bus.done), 64'd0);
        chk("midrst stat", 64'(bus.stat), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("midrst dones", 64'(dones), 64'd0);
        run_op("ld_20", 4'd5, 64'h20, 64'h0, 64'h0,
               1'b1, 1'b0, 64'h0123456789ABCDEF, 3'd1);

        // start held for three cycles.
        @(negedge clk);
        drive(4'd5, 64'h10, 64'h0, 64'h0, 1'b1, 1'b0);
        dones = 0;
        busy1 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) busy1 = bus.busy;
            if (i == 3) bus.start = 1'b0;
            if (bus.done) dones++;
        end
        chk("hold3 busy", 64'(busy1), 64'd1);
        chk("hold3 dones", 64'(dones), 64'd1);
        chk("hold3 valM", bus.valM, 64'h1122334455667788);
        chk("hold3 busy_end", 64'(bus.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter MEM_BYTES, default 1024, sets data memory size in bytes (byte-addressable, multiple of 8, minimum 16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle pulse: execute-stage results are valid this cycle.
REQ-005 icode  input  4  instruction code of the current instruction.
REQ-006 valE  input  64  execute-stage result: address or new stack pointer.
REQ-007 valA  input  64  register operand: store data or pop/ret address.
REQ-008 valP  input  64  next-PC value, stored by call.
REQ-009 instr_valid  input  1  fetch flag: 0 means illegal instruction.
REQ-010 imem_error  input  1  fetch flag: 1 means instruction address error.
REQ-011 valM  output  64  value read from data memory.
REQ-012 done  output  1  one-cycle pulse: valM and stat are valid.
REQ-013 busy  output  1  high while an access is in flight.
REQ-014 stat  output  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS, HALTED.
REQ-016 IDLE with start=1 SHALL capture icode, valE, valA, valP, instr_valid and imem_error, then go to ACCESS; busy=1 in ACCESS only.
REQ-017 start SHALL be ignored in ACCESS and HALTED; captured operands SHALL NOT change during ACCESS.
REQ-018 ACCESS SHALL last exactly one cycle; the next edge SHALL set done=1 for one cycle and update valM and stat, giving start-to-done latency of 2 edges.
REQ-019 Write ops (address, data): rmmovq icode 4 (valE, valA); pushq icode 10 (valE, valA); call icode 8 (valE, valP).
REQ-020 Read ops (address, result in valM): mrmovq icode 5 (valE); popq icode 11 (valA); ret icode 9 (valA).
REQ-021 All other icodes SHALL perform no memory access and SHALL hold valM at its previous value.
REQ-022 Accesses SHALL be 8 bytes, little-endian: byte addr holds bits [7:0] and byte addr+7 holds bits [63:56].
REQ-023 Address comparison SHALL be unsigned: an address greater than MEM_BYTES-8 is invalid, including when addr+7 wraps past 2^64.
REQ-024 On an invalid address: no byte SHALL be written, valM SHALL be 0, stat SHALL be ADR.
REQ-025 stat priority, highest first: imem_error gives ADR; instr_valid=0 gives INS; data address error gives ADR; icode 0 gives HLT; otherwise AOK.
REQ-026 If captured imem_error=1 or instr_valid=0, no memory write SHALL occur.
REQ-027 If the final stat is not AOK, the FSM SHALL move to HALTED after done; otherwise it SHALL return to IDLE.
REQ-028 HALTED SHALL keep stat, keep valM, hold done=0, and remain until reset.
REQ-029 Reads and writes SHALL never target the same address in the same cycle, since there is one access per instruction.

Reset
REQ-030 With rst=1 at an edge: state=IDLE, valM=0, done=0, busy=0, stat=AOK(1).
REQ-031 Reset SHALL take priority over start and over an ACCESS in flight: a write pending in ACCESS SHALL be dropped and no done SHALL follow.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 Store/load: rmmovq valE=0x10, valA=0x1122334455667788, then mrmovq valE=0x10 -> done 2 edges after each start; valM=0x1122334455667788; byte 0x10=0x88; stat=1.
REQ-034 Push/pop/call/ret: pushq valE=0x3F8, valA=5, then popq valA=0x3F8 -> valM=5; call valE=0x3F0, valP=0x40, then ret valA=0x3F0 -> valM=0x40.
REQ-035 Boundary (MEM_BYTES=1024): mrmovq valE=0x3F8 -> AOK. rmmovq valE=0x3F9 -> stat=3, memory unchanged, HALTED. Further start pulses -> no done. valE=0xFFFFFFFFFFFFFFFC -> stat=3.
REQ-036 Status: icode=0 -> stat=2, then HALTED. instr_valid=0 with icode 4 -> stat=4, no write. imem_error=1 together with instr_valid=0 -> stat=3.
REQ-037 Reset mid-operation: assert rst in the ACCESS cycle of rmmovq to 0x20 -> no done, target bytes unchanged, stat=1. After reset, mrmovq from a previously written address returns the old data.
REQ-038 start held high for 3 cycles -> exactly one access and one done for the first pulse; busy=1 in the second cycle.
